// File: rtl/shift_right_unit.sv
// Multi-cycle SRL/SRA shifter: moves STEP bits per clock under a Start/Busy/Done handshake.
// Zero/Sign are derived combinationally from the registered Result, like the ALU flags.
module shift_right_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Arith,
  input  logic [SHAMT_W-1:0] ShiftAmt,
  input  logic [WIDTH-1:0]   Operand,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Sign
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] remain;
  logic               fill;
  logic               last;
  logic [WIDTH-1:0]   sh_final, sh_step;

  // Right shift with a chosen fill bit; n may reach WIDTH, which yields all fill.
  function automatic logic [WIDTH-1:0] fshr(input logic [WIDTH-1:0] d, input logic f,
                                            input logic [SHAMT_W:0] n);
    logic [WIDTH-1:0] ones;
    ones = '1;
    return (d >> n) | (f ? ~(ones >> n) : '0);
  endfunction

  assign last     = ({1'b0, remain} <= STEP_W);
  assign sh_final = fshr(data, fill, {1'b0, remain});
  assign sh_step  = fshr(data, fill, STEP_W);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Datapath: inputs are sampled only at the accept edge; Result moves only on entry to DONE.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      data   <= '0;
      remain <= '0;
      fill   <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          data   <= Operand;
          remain <= ShiftAmt;
          fill   <= Arith & Operand[WIDTH-1];
        end
        SHIFT: if (last) begin
          Result <= sh_final;
        end else begin
          data   <= sh_step;
          remain <= remain - STEP_W[SHAMT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign Zero = (Result == '0);
  assign Sign = Result[WIDTH-1];

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed bench for shift_right_unit: one STEP=1 and one STEP=4 instance on a shared clock/reset.
module tb_shift_right_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start [2];
  logic        arith [2];
  logic [4:0]  amt   [2];
  logic [31:0] opnd  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] res   [2];
  logic        zero  [2];
  logic        sign  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u0 (
    .CLK(CLK), .Reset(Reset), .Start(start[0]), .Arith(arith[0]), .ShiftAmt(amt[0]),
    .Operand(opnd[0]), .Busy(busy[0]), .Done(done[0]), .Result(res[0]),
    .Zero(zero[0]), .Sign(sign[0]));

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .CLK(CLK), .Reset(Reset), .Start(start[1]), .Arith(arith[1]), .ShiftAmt(amt[1]),
    .Operand(opnd[1]), .Busy(busy[1]), .Done(done[1]), .Result(res[1]),
    .Zero(zero[1]), .Sign(sign[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the unit to be idle, then presents one request for exactly one accept edge.
  task automatic start_op(input int u, input logic [31:0] op, input logic ar, input logic [4:0] sh);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy[u] && n < 50) begin @(negedge CLK); n++; end
    opnd[u] = op; arith[u] = ar; amt[u] = sh; start[u] = 1'b1;
    @(posedge CLK);
    acc = cyc + 1;
    #1;
    start[u] = 1'b0;
    opnd[u]  = ~op;
    arith[u] = ~ar;
    amt[u]   = ~sh;
    chk($sformatf("busy_after_accept_u%0d", u), 32'(busy[u]), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int u, input logic [31:0] exp, input int lat);
    while (!done[u] && (cyc - acc) < 200) begin @(posedge CLK); #1; end
    chk({tag, "_done"}, 32'(done[u]), 32'd1);
    chk({tag, "_lat"},  32'(cyc - acc), 32'(lat));
    chk({tag, "_res"},  res[u], exp);
    chk({tag, "_zero"}, 32'(zero[u]), 32'(exp == 32'd0));
    chk({tag, "_sign"}, 32'(sign[u]), 32'(exp[31]));
  endtask

  initial begin
    int pulses;
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; arith[i] = 1'b0; amt[i] = 5'd0; opnd[i] = 32'd0;
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_res",  res[0], 32'd0);
    chk("rst_zero", 32'(zero[0]), 32'd1);
    chk("rst_sign", 32'(sign[0]), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // T1..T3 on the STEP=1 unit, issued back to back
    start_op(0, 32'h8000_0000, 1'b0, 5'd31);
    wait_done("t1", 0, 32'h0000_0001, 31);
    start_op(0, 32'h8000_0000, 1'b1, 5'd4);
    wait_done("t2", 0, 32'hF800_0000, 4);
    start_op(0, 32'h1234_5678, 1'b0, 5'd0);
    wait_done("t3", 0, 32'h1234_5678, 1);
    @(posedge CLK); #1;
    chk("t3_done_one_cycle", 32'(done[0]), 32'd0);
    chk("t3_res_held", res[0], 32'h1234_5678);

    // T4: a Start pulse while busy is dropped, not queued
    start_op(0, 32'h0000_000F, 1'b0, 5'd4);
    @(negedge CLK);
    opnd[0] = 32'hFFFF_FFFF; arith[0] = 1'b1; amt[0] = 5'd0; start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    wait_done("t4", 0, 32'h0000_0000, 4);
    repeat (3) @(posedge CLK);
    #1;
    chk("t4_not_queued_busy", 32'(busy[0]), 32'd0);
    chk("t4_res_held", res[0], 32'h0000_0000);

    // T5 and extras on the STEP=4 unit
    start_op(1, 32'hFFFF_FFFF, 1'b0, 5'd7);
    wait_done("t5", 1, 32'h01FF_FFFF, 2);
    start_op(1, 32'hF000_0000, 1'b0, 5'd4);
    wait_done("s4_eq_step", 1, 32'h0F00_0000, 1);
    start_op(1, 32'h8000_0000, 1'b1, 5'd31);
    wait_done("s4_sra31", 1, 32'hFFFF_FFFF, 8);
    start_op(1, 32'hABCD_0000, 1'b1, 5'd0);
    wait_done("s4_zero_amt", 1, 32'hABCD_0000, 1);

    // T6: async reset in the middle of a SHIFT after a prior Result
    start_op(0, 32'h0001_2340, 1'b0, 5'd4);
    wait_done("t6_pre", 0, 32'h0000_1234, 4);
    start_op(0, 32'h0000_FFFF, 1'b0, 5'd20);
    repeat (3) @(posedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy[0]), 32'd0);
    chk("t6_done", 32'(done[0]), 32'd0);
    chk("t6_res",  res[0], 32'd0);
    chk("t6_zero", 32'(zero[0]), 32'd1);
    @(negedge CLK);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done[0]) pulses++;
    end
    chk("t6_no_done", 32'(pulses), 32'd0);
    chk("t6_idle", 32'(busy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
